// File: rtl/scale_pkg.sv
// Shared parameters and FSM encoding for the scaler coordinate generator.
// Modules take these values as the defaults for their own parameters.
package scale_pkg;

    localparam int CW = 12;
    localparam int FB = 16;
    localparam int WB = 9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/coord_clamp.sv
// Turns a signed fixed-point source position into a pair of source indices
// and the two interpolation weights, clamped to the source line.
module coord_clamp #(
    parameter int CW = scale_pkg::CW,
    parameter int FB = scale_pkg::FB,
    parameter int WB = scale_pkg::WB
) (
    input  logic signed [CW+FB:0] acc,
    input  logic [CW-1:0]         src_w,
    output logic [CW-1:0]         x0,
    output logic [CW-1:0]         x1,
    output logic [WB-1:0]         w0,
    output logic [WB-1:0]         w1
);

    localparam logic [WB-1:0] UNITY = WB'(256);

    logic [CW-1:0] int_part;
    logic [CW-1:0] last_idx;
    logic [7:0]    frac;
    logic          unused_low_frac;

    assign int_part        = acc[CW+FB-1:FB];
    assign frac            = acc[FB-1:FB-8];
    assign last_idx        = src_w - CW'(1);
    // Only the top 8 fractional bits form the weight.
    assign unused_low_frac = ^acc[FB-9:0];

    always_comb begin
        x0 = '0;
        x1 = '0;
        w1 = '0;
        if (!acc[CW+FB]) begin
            if (int_part >= last_idx) begin
                x0 = last_idx;
                x1 = last_idx;
            end else begin
                x0 = int_part;
                x1 = int_part + CW'(1);
                w1 = WB'(frac);
            end
        end
    end

    assign w0 = UNITY - w1;

endmodule

// File: rtl/scale_coord_gen.sv
// Per-line source coordinate / weight generator for a horizontal scaler.
// One start pulse yields dst_w registered tuples under valid/ready flow control.
module scale_coord_gen #(
    parameter int CW = scale_pkg::CW,
    parameter int FB = scale_pkg::FB,
    parameter int WB = scale_pkg::WB
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CW-1:0]    src_w,
    input  logic [CW-1:0]    dst_w,
    input  logic [CW+FB-1:0] step,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [CW-1:0]    o_x0,
    output logic [CW-1:0]    o_x1,
    output logic [WB-1:0]    o_w0,
    output logic [WB-1:0]    o_w1,
    output logic             o_last,
    output logic             busy
);

    import scale_pkg::state_t;
    import scale_pkg::ST_IDLE;
    import scale_pkg::ST_INIT;
    import scale_pkg::ST_RUN;

    localparam int AW = CW + FB + 1;
    localparam logic signed [AW-1:0] CENTRE =
        $signed({{(CW+1){1'b0}}, 1'b1, {(FB-1){1'b0}}});

    state_t state_reg, state_next;

    logic [CW-1:0]    src_w_reg;
    logic [CW-1:0]    dst_w_reg;
    logic [CW+FB-1:0] step_reg;
    logic [CW-1:0]    n_reg;

    logic signed [AW-1:0] acc_reg;
    logic signed [AW-1:0] half_step;
    logic signed [AW-1:0] init_acc;
    logic signed [AW-1:0] acc_step;
    logic signed [AW-1:0] acc_sel;

    logic [CW-1:0] cl_x0, cl_x1;
    logic [WB-1:0] cl_w0, cl_w1;
    logic [CW-1:0] n_inc;
    logic [CW-1:0] last_n;
    logic          handshake;
    logic          launch;

    assign half_step = $signed({2'b00, step_reg[CW+FB-1:1]});
    assign init_acc  = half_step - CENTRE;
    assign acc_step  = acc_reg + $signed({1'b0, step_reg});
    // Output registers always load the position of the tuple about to be shown.
    assign acc_sel   = (state_reg == ST_INIT) ? init_acc : acc_step;

    assign n_inc     = n_reg + CW'(1);
    assign last_n    = dst_w_reg - CW'(1);
    assign handshake = o_valid && o_ready;
    assign launch    = (state_reg == ST_IDLE) && start && (dst_w != '0);
    assign busy      = (state_reg != ST_IDLE);

    coord_clamp #(
        .CW(CW),
        .FB(FB),
        .WB(WB)
    ) u_clamp (
        .acc  (acc_sel),
        .src_w(src_w_reg),
        .x0   (cl_x0),
        .x1   (cl_x1),
        .w0   (cl_w0),
        .w1   (cl_w1)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (launch) state_next = ST_INIT;
            ST_INIT: state_next = ST_RUN;
            ST_RUN:  if (handshake && o_last) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_w_reg <= '0;
            dst_w_reg <= '0;
            step_reg  <= '0;
            acc_reg   <= '0;
            n_reg     <= '0;
            o_valid   <= 1'b0;
            o_last    <= 1'b0;
            o_x0      <= '0;
            o_x1      <= '0;
            o_w0      <= '0;
            o_w1      <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (launch) begin
                        src_w_reg <= src_w;
                        dst_w_reg <= dst_w;
                        step_reg  <= step;
                    end
                end
                ST_INIT: begin
                    acc_reg <= init_acc;
                    n_reg   <= '0;
                    o_valid <= 1'b1;
                    o_last  <= (dst_w_reg == CW'(1));
                    o_x0    <= cl_x0;
                    o_x1    <= cl_x1;
                    o_w0    <= cl_w0;
                    o_w1    <= cl_w1;
                end
                ST_RUN: begin
                    if (handshake) begin
                        if (o_last) begin
                            o_valid <= 1'b0;
                            o_last  <= 1'b0;
                        end else begin
                            acc_reg <= acc_step;
                            n_reg   <= n_inc;
                            o_last  <= (n_inc == last_n);
                            o_x0    <= cl_x0;
                            o_x1    <= cl_x1;
                            o_w0    <= cl_w0;
                            o_w1    <= cl_w1;
                        end
                    end
                end
                default: begin
                    o_valid <= 1'b0;
                    o_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scale_coord_gen.sv
// Scoreboard bench for scale_coord_gen: expected tuples come from a per-index
// arithmetic model; a monitor pops and compares on every handshake.
module tb_scale_coord_gen;

    localparam int CW = 12;
    localparam int FB = 16;
    localparam int WB = 9;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [CW-1:0]    src_w = '0;
    logic [CW-1:0]    dst_w = '0;
    logic [CW+FB-1:0] step = '0;
    logic             o_valid;
    logic             o_ready = 1'b1;
    logic [CW-1:0]    o_x0, o_x1;
    logic [WB-1:0]    o_w0, o_w1;
    logic             o_last;
    logic             busy;

    typedef struct packed {
        logic [CW-1:0] x0;
        logic [CW-1:0] x1;
        logic [WB-1:0] w0;
        logic [WB-1:0] w1;
        logic          last;
    } tuple_t;

    tuple_t exp_q[$];
    int vectors = 0;
    int miscompares = 0;
    int hs_count = 0;
    int ready_mode = 0;

    scale_coord_gen #(.CW(CW), .FB(FB), .WB(WB)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .src_w(src_w), .dst_w(dst_w), .step(step),
        .o_valid(o_valid), .o_ready(o_ready),
        .o_x0(o_x0), .o_x1(o_x1), .o_w0(o_w0), .o_w1(o_w1),
        .o_last(o_last), .busy(busy)
    );

    always #5 clk = ~clk;

    // ready: 0 = always high, 1 = random, 2 = held low
    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       o_ready = 1'b1;
                1:       o_ready = ($urandom_range(0, 3) != 0);
                default: o_ready = 1'b0;
            endcase
        end
    end

    initial begin
        tuple_t cur, held, e;
        logic prev_stall;
        prev_stall = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                cur = '{x0: o_x0, x1: o_x1, w0: o_w0, w1: o_w1, last: o_last};
                if (prev_stall) begin
                    vectors++;
                    if (!o_valid || cur != held) begin
                        miscompares++;
                        $display("FAIL hold: got v=%0d x0=%0d x1=%0d w0=%0d w1=%0d last=%0d expected v=1 x0=%0d x1=%0d w0=%0d w1=%0d last=%0d",
                                 o_valid, cur.x0, cur.x1, cur.w0, cur.w1, cur.last,
                                 held.x0, held.x1, held.w0, held.w1, held.last);
                    end
                end
                if (o_valid && o_ready) begin
                    hs_count++;
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL unexpected_tuple: got x0=%0d x1=%0d w0=%0d w1=%0d last=%0d expected none",
                                 cur.x0, cur.x1, cur.w0, cur.w1, cur.last);
                    end else begin
                        e = exp_q.pop_front();
                        if (cur != e) begin
                            miscompares++;
                            $display("FAIL tuple: got x0=%0d x1=%0d w0=%0d w1=%0d last=%0d expected x0=%0d x1=%0d w0=%0d w1=%0d last=%0d",
                                     cur.x0, cur.x1, cur.w0, cur.w1, cur.last,
                                     e.x0, e.x1, e.w0, e.w1, e.last);
                        end
                    end
                end
                prev_stall = o_valid && !o_ready;
                held = cur;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp_v);
        vectors++;
        if (act != exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    // Source position of output k is (k + 0.5) * step - 0.5 in pixel units.
    task automatic push_model(input int src, input int dst, input longint st);
        for (int k = 0; k < dst; k++) begin
            longint a;
            int x0, x1, w1;
            tuple_t t;
            a = st * k + st / 2 - 32768;
            if (a < 0) begin
                x0 = 0; x1 = 0; w1 = 0;
            end else begin
                x0 = int'(a / 65536);
                w1 = int'((a / 256) % 256);
                if (x0 >= src - 1) begin
                    x0 = src - 1;
                    w1 = 0;
                end
                x1 = (x0 + 1 < src - 1) ? x0 + 1 : src - 1;
            end
            t.x0 = CW'(x0);
            t.x1 = CW'(x1);
            t.w1 = WB'(w1);
            t.w0 = WB'(256 - w1);
            t.last = (k == dst - 1);
            exp_q.push_back(t);
        end
    endtask

    task automatic run_line(input int src, input int dst, input longint st);
        @(posedge clk); #1;
        start = 1'b1;
        src_w = CW'(src);
        dst_w = CW'(dst);
        step  = (CW+FB)'(st);
        if (dst > 0) push_model(src, dst, st);
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", int'(busy), (dst > 0) ? 1 : 0);
        check("valid_in_init", int'(o_valid), 0);
        @(posedge clk); #1;
        check("valid_first_run", int'(o_valid), (dst > 0) ? 1 : 0);
    endtask

    task automatic wait_idle(input string name);
        for (int c = 0; c < 3000; c++) begin
            if (exp_q.size() == 0 && !busy) break;
            @(posedge clk); #1;
        end
        check(name, exp_q.size() + int'(busy), 0);
    endtask

    task automatic wait_hs(input int target);
        for (int c = 0; c < 200; c++) begin
            if (hs_count >= target) break;
            @(posedge clk); #1;
        end
        check("wait_handshakes", (hs_count >= target) ? 1 : 0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        @(posedge clk); #1;
        check("rst_valid", int'(o_valid), 0);
        check("rst_busy",  int'(busy), 0);
        check("rst_x0",    int'(o_x0), 0);
        check("rst_x1",    int'(o_x1), 0);
        check("rst_w0",    int'(o_w0), 0);
        check("rst_w1",    int'(o_w1), 0);
        check("rst_last",  int'(o_last), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_after_rst", int'(o_valid) + int'(busy), 0);

        // identity, 2x up, 2x down
        run_line(4, 4, 64'h10000);  wait_idle("done_identity");
        run_line(4, 8, 64'h8000);   wait_idle("done_up2");
        run_line(8, 4, 64'h20000);  wait_idle("done_down2");

        // backpressure mid-line
        base = hs_count;
        run_line(4, 8, 64'h8000);
        wait_hs(base + 3);
        ready_mode = 2;
        repeat (3) @(posedge clk);
        #1;
        ready_mode = 0;
        wait_idle("done_backpressure");
        check("bp_count", hs_count - base, 8);

        // zero-length line
        run_line(5, 0, 64'h10000);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("dst0_quiet", int'(o_valid) + int'(busy), 0);
        end

        // start while busy is ignored
        base = hs_count;
        run_line(6, 5, (64'd6 << 16) / 5);
        @(posedge clk); #1;
        start = 1'b1; src_w = 12'd3; dst_w = 12'd9; step = 28'h5555;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle("done_busy_start");
        check("busy_start_count", hs_count - base, 5);

        // asynchronous reset mid-line, then a clean line
        base = hs_count;
        run_line(4, 8, 64'h8000);
        wait_hs(base + 3);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", int'(o_valid), 0);
        check("mid_rst_busy",  int'(busy), 0);
        check("mid_rst_x0",    int'(o_x0), 0);
        check("mid_rst_x1",    int'(o_x1), 0);
        check("mid_rst_w0",    int'(o_w0), 0);
        check("mid_rst_w1",    int'(o_w1), 0);
        check("mid_rst_last",  int'(o_last), 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("post_rst_quiet", int'(o_valid) + int'(busy), 0);
        end
        base = hs_count;
        run_line(4, 8, 64'h8000);
        wait_idle("done_after_rst");
        check("after_rst_count", hs_count - base, 8);

        // random ratios with random backpressure
        ready_mode = 1;
        for (int r = 0; r < 25; r++) begin
            int s, d;
            longint st;
            s  = $urandom_range(1, 300);
            d  = $urandom_range(1, 48);
            st = (longint'(s) << 16) / d + longint'($urandom_range(0, 255));
            base = hs_count;
            run_line(s, d, st);
            wait_idle("done_random");
            check("random_count", hs_count - base, d);
        end
        ready_mode = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/scale_coord_gen.md
SCALE_COORD_GEN -- requirements
Module: scale_coord_gen

Interface
REQ-001 SHALL have parameter CW, default 12, meaning coordinate and dimension width in bits.
REQ-002 SHALL have parameter FB, default 16, meaning fractional bits of the step and accumulator.
REQ-003 SHALL have parameter WB, default 9, meaning bit width of each interpolation weight.
REQ-004 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  in  1  one-cycle pulse that launches one line of coordinates.
REQ-007 SHALL have port src_w  in  CW  source line length in pixels.
REQ-008 SHALL have port dst_w  in  CW  destination line length in pixels.
REQ-009 SHALL have port step  in  CW+FB  unsigned fixed-point ratio src_w/dst_w, with FB fractional bits.
REQ-010 SHALL have port o_valid  out  1  output tuple is valid.
REQ-011 SHALL have port o_ready  in  1  downstream accepts the tuple.
REQ-012 SHALL have port o_x0  out  CW  left source index.
REQ-013 SHALL have port o_x1  out  CW  right source index.
REQ-014 SHALL have port o_w0  out  WB  weight of x0.
REQ-015 SHALL have port o_w1  out  WB  weight of x1.
REQ-016 SHALL have port o_last  out  1  marks the final tuple of the line.
REQ-017 SHALL have port busy  out  1  a line is in progress.

Function
REQ-018 SHALL implement states IDLE -> INIT -> RUN -> IDLE.
REQ-019 In IDLE, start SHALL latch src_w, dst_w and step and move to INIT; if dst_w==0 it SHALL stay in IDLE and emit no tuples.
REQ-020 INIT SHALL load a signed accumulator acc = step/2 - 2^(FB-1) (centre alignment), clear the output counter n, then enter RUN.
REQ-021 RUN SHALL present a tuple on o_valid for the current acc and n.
REQ-022 A handshake (o_valid && o_ready) SHALL advance acc += step and n += 1; the tuple with n==dst_w-1 SHALL assert o_last, and its handshake SHALL return the FSM to IDLE.
REQ-023 While o_valid && !o_ready, all outputs SHALL hold stable.
REQ-024 For acc < 0, the tuple SHALL be x0 = 0, x1 = 0, w1 = 0.
REQ-025 For acc >= 0, the tuple SHALL be x0 = acc integer part, w1 = acc[FB-1:FB-8], both before clamping.
REQ-026 If x0 >= src_w-1, the tuple SHALL clamp to x0 = src_w-1 and w1 = 0.
REQ-027 x1 SHALL equal min(x0+1, src_w-1).
REQ-028 w0 SHALL equal 256 - w1 in every case (range 1..256).
REQ-029 The accumulator SHALL be CW+FB+1 bits wide and signed; no intermediate truncation.
REQ-030 The output SHALL be registered: o_valid is first asserted 2 cycles after start (INIT, then first RUN cycle), then one tuple per cycle while o_ready is held high.
REQ-031 start while busy SHALL be ignored.
REQ-032 busy SHALL be high in INIT and RUN.

Reset
REQ-033 rst_n low SHALL asynchronously force IDLE and clear acc, n, o_valid, o_last, busy, o_x0, o_x1 and o_w1, and set o_w0 = 0, including mid-line.
REQ-034 After reset release, the block SHALL emit nothing until the next start.

Structure
REQ-035 Parameters CW, FB and WB and the FSM state encoding SHALL live in a shared package, scale_pkg.
REQ-036 The clamp/weight logic SHALL be one sub-module, coord_clamp (acc, src_w -> x0, x1, w0, w1), kept combinational, with its results registered in scale_coord_gen.

Verification
REQ-037 Identity scale: src=4, dst=4, step=0x10000 -> (x0,x1,w1) = (0,1,0), (1,2,0), (2,3,0), (3,3,0); o_last on the 4th tuple.
REQ-038 2x upscale: src=4, dst=8, step=0x8000 -> w1 sequence 0, 0x40, 0xC0, 0x40, 0xC0, 0x40, 0xC0, 0; x0 sequence 0, 0, 0, 1, 1, 2, 2, 3.
REQ-039 2x downscale: src=8, dst=4, step=0x20000 -> x0 = 0, 2, 4, 6; w1 = 0x80 each; w0 = 0x80 each.
REQ-040 Backpressure: drop o_ready for 3 cycles mid-line -> tuple held unchanged; no tuple lost or duplicated.
REQ-041 dst_w=0 start -> o_valid never asserts and busy stays low; start while busy -> ignored, line completes normally.
REQ-042 Reset asserted at tuple 3 of 8 -> all outputs 0 immediately; a new start produces a full, correct line.
